// File: rtl/uart_tx_frame_ctrl.sv
// UART transmitter: start bit, LSB-first data, optional parity, one or two stop bits.
// One bit per CLK; a new word can be taken in the final stop cycle for gapless frames.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  DATA_ACK,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         nxt_bit;
  logic                  stop_cnt;
  logic                  last_stop;
  logic                  accept;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign nxt_bit   = bit_cnt + CW'(1);
  assign last_stop = (stop_cnt == stop2_q);
  assign accept    = DATA_VALID && ((state == IDLE) || ((state == STOP) && last_stop));

  // Payload register carries no reset; it is only read after an accept.
  always_ff @(posedge CLK) begin
    if (accept) data_q <= P_DATA;
  end

  // Outputs are registered with the value belonging to the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      DATA_ACK  <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      DATA_ACK <= 1'b0;
      if (accept) begin
        state     <= START;
        TX_OUT    <= 1'b0;
        busy      <= 1'b1;
        DATA_ACK  <= 1'b1;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
          START: begin
            state  <= DATA;
            TX_OUT <= data_q[0];
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= parity_bit(data_q, par_typ_q);
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_cnt <= nxt_bit;
              TX_OUT  <= data_q[nxt_bit];
            end
          end
          PARITY: begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
          STOP: begin
            if (last_stop) begin
              state    <= IDLE;
              busy     <= 1'b0;
              TX_OUT   <= 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy   <= 1'b0;
            TX_OUT <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl at DATA_WIDTH 8 and 5.
module tb_uart_tx_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pd8 = '0;
  logic [4:0] pd5 = '0;
  logic       dv8 = 1'b0;
  logic       dv5 = 1'b0;
  logic       pe  = 1'b0;
  logic       pt  = 1'b0;
  logic       s2  = 1'b0;
  logic       ack8, tx8, busy8;
  logic       ack5, tx5, busy5;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(pd8), .DATA_VALID(dv8), .PAR_EN(pe),
    .PAR_TYP(pt), .STOP2(s2), .DATA_ACK(ack8), .TX_OUT(tx8), .busy(busy8)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(pd5), .DATA_VALID(dv5), .PAR_EN(pe),
    .PAR_TYP(pt), .STOP2(s2), .DATA_ACK(ack5), .TX_OUT(tx5), .busy(busy5)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference frame builder: pushes the expected line bits for one frame.
  task automatic push_frame(input logic [8:0] d, input int w, input logic pe_i,
                            input logic pt_i, input logic s2_i);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int k = 0; k < w; k++) begin
      exp_q.push_back(d[k]);
      p = p ^ d[k];
    end
    if (pe_i) exp_q.push_back(p ^ pt_i);
    exp_q.push_back(1'b1);
    if (s2_i) exp_q.push_back(1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dv8 = 1'b1;
    dv5 = 1'b1;
    pd8 = 8'h3C;
    tick();
    tick();
    tests++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || ack8 !== 1'b0) begin
      fails++;
      $display("FAIL reset8 tx=%b busy=%b ack=%b, want tx=1 busy=0 ack=0", tx8, busy8, ack8);
    end
    tests++;
    if (tx5 !== 1'b1 || busy5 !== 1'b0 || ack5 !== 1'b0) begin
      fails++;
      $display("FAIL reset5 tx=%b busy=%b ack=%b, want tx=1 busy=0 ack=0", tx5, busy5, ack5);
    end
    dv8 = 1'b0;
    dv5 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_parity_even;
    int n;
    logic e;
    pd8 = 8'hA5; pe = 1'b1; pt = 1'b0; s2 = 1'b0;
    push_frame({1'b0, pd8}, 8, pe, pt, s2);
    dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (tx8 !== e || busy8 !== 1'b1 || ack8 !== (i == 0)) begin
        fails++;
        $display("FAIL even_a5 cyc%0d tx=%b busy=%b ack=%b, want tx=%b busy=1 ack=%b",
                 i, tx8, busy8, ack8, e, (i == 0));
      end
      tick();
    end
    tests++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || ack8 !== 1'b0) begin
      fails++;
      $display("FAIL even_a5 idle tx=%b busy=%b ack=%b, want 1/0/0", tx8, busy8, ack8);
    end
  endtask

  task automatic test_parity_odd_stop2;
    int n;
    logic e;
    pd8 = 8'h01; pe = 1'b1; pt = 1'b1; s2 = 1'b1;
    push_frame({1'b0, pd8}, 8, pe, pt, s2);
    dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (tx8 !== e || busy8 !== 1'b1 || ack8 !== (i == 0)) begin
        fails++;
        $display("FAIL odd_stop2 cyc%0d tx=%b busy=%b ack=%b, want tx=%b busy=1 ack=%b",
                 i, tx8, busy8, ack8, e, (i == 0));
      end
      tick();
    end
    tests++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      fails++;
      $display("FAIL odd_stop2 idle tx=%b busy=%b, want 1/0", tx8, busy8);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int acks;
    logic e;
    pe = 1'b0; pt = 1'b0; s2 = 1'b0;
    pd8 = 8'h55;
    push_frame(9'h055, 8, 1'b0, 1'b0, 1'b0);
    push_frame(9'h0AA, 8, 1'b0, 1'b0, 1'b0);
    dv8 = 1'b1;
    tick();
    pd8 = 8'hAA;
    acks = 0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (ack8 === 1'b1) acks++;
      tests++;
      if (tx8 !== e || busy8 !== 1'b1 || ack8 !== (i == 0 || i == 10)) begin
        fails++;
        $display("FAIL b2b cyc%0d tx=%b busy=%b ack=%b, want tx=%b busy=1 ack=%b",
                 i, tx8, busy8, ack8, e, (i == 0 || i == 10));
      end
      if (i == 10) dv8 = 1'b0;
      tick();
    end
    tests++;
    if (acks != 2 || busy8 !== 1'b0 || tx8 !== 1'b1) begin
      fails++;
      $display("FAIL b2b end acks=%0d busy=%b tx=%b, want acks=2 busy=0 tx=1", acks, busy8, tx8);
    end
  endtask

  task automatic test_abort;
    int n;
    logic e;
    pd8 = 8'hFF; pe = 1'b0; pt = 1'b0; s2 = 1'b0;
    dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (tx8 !== (i != 0) || busy8 !== 1'b1) begin
        fails++;
        $display("FAIL abort_pre cyc%0d tx=%b busy=%b, want tx=%b busy=1", i, tx8, busy8, (i != 0));
      end
      if (i == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    tests++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || ack8 !== 1'b0) begin
      fails++;
      $display("FAIL abort tx=%b busy=%b ack=%b, want 1/0/0", tx8, busy8, ack8);
    end
    tick();
    pd8 = 8'h3C; pe = 1'b1; pt = 1'b0;
    push_frame({1'b0, pd8}, 8, pe, pt, s2);
    dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (tx8 !== e || busy8 !== 1'b1 || ack8 !== (i == 0)) begin
        fails++;
        $display("FAIL post_abort cyc%0d tx=%b busy=%b ack=%b, want tx=%b busy=1 ack=%b",
                 i, tx8, busy8, ack8, e, (i == 0));
      end
      tick();
    end
    tests++;
    if (busy8 !== 1'b0 || tx8 !== 1'b1) begin
      fails++;
      $display("FAIL post_abort idle busy=%b tx=%b, want 0/1", busy8, tx8);
    end
  endtask

  task automatic test_width5;
    int n;
    logic e;
    pd5 = 5'h1F; pe = 1'b1; pt = 1'b0; s2 = 1'b0;
    push_frame({4'b0, pd5}, 5, pe, pt, s2);
    dv5 = 1'b1;
    tick();
    dv5 = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (tx5 !== e || busy5 !== 1'b1 || ack5 !== (i == 0)) begin
        fails++;
        $display("FAIL w5 cyc%0d tx=%b busy=%b ack=%b, want tx=%b busy=1 ack=%b",
                 i, tx5, busy5, ack5, e, (i == 0));
      end
      tick();
    end
    tests++;
    if (busy5 !== 1'b0 || tx5 !== 1'b1) begin
      fails++;
      $display("FAIL w5 idle busy=%b tx=%b, want 0/1", busy5, tx5);
    end
  endtask

  task automatic test_midframe_ignore;
    int n;
    logic e;
    pd8 = 8'h96; pe = 1'b1; pt = 1'b1; s2 = 1'b1;
    push_frame({1'b0, pd8}, 8, pe, pt, s2);
    dv8 = 1'b1;
    tick();
    dv8 = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      tests++;
      if (tx8 !== e || busy8 !== 1'b1 || ack8 !== (i == 0)) begin
        fails++;
        $display("FAIL midframe cyc%0d tx=%b busy=%b ack=%b, want tx=%b busy=1 ack=%b",
                 i, tx8, busy8, ack8, e, (i == 0));
      end
      if (i == 3) begin
        dv8 = 1'b1;
        pd8 = 8'h00;
      end
      if (i == 4) dv8 = 1'b0;
      if (i == 5) begin
        pe = 1'b0; pt = 1'b0; s2 = 1'b0;
      end
      tick();
    end
    tests++;
    if (busy8 !== 1'b0 || tx8 !== 1'b1 || ack8 !== 1'b0) begin
      fails++;
      $display("FAIL midframe idle busy=%b tx=%b ack=%b, want 0/1/0", busy8, tx8, ack8);
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd_stop2();
    test_back_to_back();
    test_abort();
    test_width5();
    test_midframe_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
